// File: rtl/ex_hilo_unit.sv
// ex_hilo_unit -- EX-stage arithmetic for every HI/LO instruction.
//
// Handles MULT/MULTU (single cycle), MADD/MADDU/MSUB/MSUBU (two cycles,
// the product is parked in EX/MEM via hilo_tmp/count), DIV/DIVU (radix-2
// restoring divider, DW+2 cycles) and the MFHI/MFLO/MTHI/MTLO moves.
// All outputs are combinational from the inputs and the divider state.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op_i                  aluop code (EXE_*_OP)
//   num1_i, num2_i        rs / rt operands
//   flush_i               annul the EX instruction, abort the divider
//   hi_i, lo_i            architectural HI/LO
//   mem_*_i, wb_*_i       MEM / WB stage HI/LO forwards
//   hilo_tmp_i, count_i   multi-cycle loop-back from EX/MEM
//   mf_data_o             MFHI/MFLO result
//   ex_en_hilo_o          HI/LO write enable
//   ex_hi_o, ex_lo_o      HI/LO write data
//   hilo_tmp_o, count_o   multi-cycle loop-back to EX/MEM
//   stallreq_o            stall request for multi-cycle ops
module ex_hilo_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      op_i,
  input  logic [DW-1:0]   num1_i,
  input  logic [DW-1:0]   num2_i,
  input  logic            flush_i,
  input  logic [DW-1:0]   hi_i,
  input  logic [DW-1:0]   lo_i,
  input  logic            mem_en_hilo_i,
  input  logic [DW-1:0]   mem_hi_i,
  input  logic [DW-1:0]   mem_lo_i,
  input  logic            wb_en_hilo_i,
  input  logic [DW-1:0]   wb_hi_i,
  input  logic [DW-1:0]   wb_lo_i,
  input  logic [2*DW-1:0] hilo_tmp_i,
  input  logic [1:0]      count_i,
  output logic [DW-1:0]   mf_data_o,
  output logic            ex_en_hilo_o,
  output logic [DW-1:0]   ex_hi_o,
  output logic [DW-1:0]   ex_lo_o,
  output logic [2*DW-1:0] hilo_tmp_o,
  output logic [1:0]      count_o,
  output logic            stallreq_o
);

  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MADD  = 8'b1010_0110;
  localparam logic [7:0] OP_MADDU = 8'b1010_1000;
  localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
  localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} div_state_t;

  div_state_t    state;
  logic [DW-1:0] quo;
  logic [DW-1:0] rem;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;

  // Magnitude of an operand; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude and makes the INT_MIN / -1 case wrap.
  function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] v,
                                            input logic is_signed);
    return (is_signed && v[DW-1]) ? -v : v;
  endfunction

  function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v,
                                           input logic neg);
    return neg ? -v : v;
  endfunction

  logic is_div;
  logic div_signed;
  logic mul_signed;
  assign is_div     = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign div_signed = (op_i == OP_DIV);
  assign mul_signed = (op_i == OP_MULT) || (op_i == OP_MADD) || (op_i == OP_MSUB);

  // Both products are formed at full 2*DW width so no sign/width
  // promotion surprises occur; the low 2*DW bits are exact in both cases.
  logic signed [2*DW-1:0] a_s;
  logic signed [2*DW-1:0] b_s;
  logic signed [2*DW-1:0] prod_s;
  logic        [2*DW-1:0] prod_u;
  logic        [2*DW-1:0] prod;
  assign a_s    = {{DW{num1_i[DW-1]}}, num1_i};
  assign b_s    = {{DW{num2_i[DW-1]}}, num2_i};
  assign prod_s = a_s * b_s;
  assign prod_u = {{DW{1'b0}}, num1_i} * {{DW{1'b0}}, num2_i};
  assign prod   = mul_signed ? $unsigned(prod_s) : prod_u;

  // Current HI/LO: the youngest in-flight write wins, as a pair.
  logic [2*DW-1:0] hilo_cur;
  always_comb begin
    if (mem_en_hilo_i)     hilo_cur = {mem_hi_i, mem_lo_i};
    else if (wb_en_hilo_i) hilo_cur = {wb_hi_i, wb_lo_i};
    else                   hilo_cur = {hi_i, lo_i};
  end

  // Restoring step: since rem < dvs always holds, trial fits in DW bits
  // when non-negative, so its top bit is a clean borrow flag.
  logic [DW:0] shifted;
  logic [DW:0] trial;
  assign shifted = {rem, quo[DW-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            neg_q <= div_signed & (num1_i[DW-1] ^ num2_i[DW-1]);
            neg_r <= div_signed & num1_i[DW-1];
            quo   <= abs_val(num1_i, div_signed);
            dvs   <= abs_val(num2_i, div_signed);
            rem   <= '0;
            cnt   <= '0;
            state <= (num2_i == '0) ? DIVZERO : BUSY;
          end
        end
        DIVZERO: begin
          quo   <= '0;
          rem   <= '0;
          state <= DONE;
        end
        BUSY: begin
          if (!trial[DW]) begin
            rem <= trial[DW-1:0];
            quo <= {quo[DW-2:0], 1'b1};
          end else begin
            rem <= shifted[DW-1:0];
            quo <= {quo[DW-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mf_data_o    = '0;
    ex_en_hilo_o = 1'b0;
    ex_hi_o      = '0;
    ex_lo_o      = '0;
    hilo_tmp_o   = '0;
    count_o      = 2'd0;
    stallreq_o   = 1'b0;
    if (state != IDLE) begin
      // An in-flight division owns EX regardless of op_i.
      if (!flush_i) begin
        if (state == DONE) begin
          ex_en_hilo_o = 1'b1;
          ex_lo_o      = neg_if(quo, neg_q);
          ex_hi_o      = neg_if(rem, neg_r);
        end else begin
          stallreq_o = 1'b1;
        end
      end
    end else begin
      case (op_i)
        OP_MFHI: mf_data_o = hilo_cur[2*DW-1:DW];
        OP_MFLO: mf_data_o = hilo_cur[DW-1:0];
        OP_MTHI: begin
          ex_en_hilo_o = 1'b1;
          ex_hi_o      = num1_i;
          ex_lo_o      = hilo_cur[DW-1:0];
        end
        OP_MTLO: begin
          ex_en_hilo_o = 1'b1;
          ex_hi_o      = hilo_cur[2*DW-1:DW];
          ex_lo_o      = num1_i;
        end
        OP_MULT, OP_MULTU: begin
          ex_en_hilo_o       = 1'b1;
          {ex_hi_o, ex_lo_o} = prod;
        end
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          if (count_i == 2'd0) begin
            hilo_tmp_o = prod;
            count_o    = 2'd1;
            stallreq_o = 1'b1;
          end else if (count_i == 2'd1) begin
            ex_en_hilo_o = 1'b1;
            count_o      = 2'd2;
            if ((op_i == OP_MADD) || (op_i == OP_MADDU))
              {ex_hi_o, ex_lo_o} = hilo_cur + hilo_tmp_i;
            else
              {ex_hi_o, ex_lo_o} = hilo_cur - hilo_tmp_i;
          end
        end
        OP_DIV, OP_DIVU: stallreq_o = ~flush_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// tb_ex_hilo_unit -- directed self-checking bench for ex_hilo_unit.
// Expected output records are queued when a step is driven and popped
// when the DUT presents the corresponding result.
module tb_ex_hilo_unit;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] MFHI  = 8'b0001_0000;
  localparam logic [7:0] MTHI  = 8'b0001_0001;
  localparam logic [7:0] MFLO  = 8'b0001_0010;
  localparam logic [7:0] MTLO  = 8'b0001_0011;
  localparam logic [7:0] MULT  = 8'b0001_1000;
  localparam logic [7:0] MULTU = 8'b0001_1001;
  localparam logic [7:0] DIV   = 8'b0001_1010;
  localparam logic [7:0] DIVU  = 8'b0001_1011;
  localparam logic [7:0] MADD  = 8'b1010_0110;
  localparam logic [7:0] MSUB  = 8'b1010_1010;
  localparam logic [7:0] MSUBU = 8'b1010_1011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  op_i;
  logic [31:0] num1_i, num2_i;
  logic        flush_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_en_hilo_i, wb_en_hilo_i;
  logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic [63:0] hilo_tmp_i;
  logic [1:0]  count_i;
  logic [31:0] mf_data_o;
  logic        ex_en_hilo_o;
  logic [31:0] ex_hi_o, ex_lo_o;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  count_o;
  logic        stallreq_o;

  ex_hilo_unit #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .num1_i(num1_i), .num2_i(num2_i),
    .flush_i(flush_i), .hi_i(hi_i), .lo_i(lo_i),
    .mem_en_hilo_i(mem_en_hilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_en_hilo_i(wb_en_hilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .hilo_tmp_i(hilo_tmp_i), .count_i(count_i),
    .mf_data_o(mf_data_o), .ex_en_hilo_o(ex_en_hilo_o),
    .ex_hi_o(ex_hi_o), .ex_lo_o(ex_lo_o),
    .hilo_tmp_o(hilo_tmp_o), .count_o(count_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        en;
    logic        stall;
    logic        care_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf;
    logic        care_tmp;
    logic [63:0] tmp;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic en, input logic stall,
                      input logic care_hl, input logic [31:0] hi, input logic [31:0] lo,
                      input logic [31:0] mf, input logic care_tmp,
                      input logic [63:0] tmp, input logic [1:0] cnt);
    exp_t e;
    e.tag = tag; e.en = en; e.stall = stall; e.care_hl = care_hl;
    e.hi = hi; e.lo = lo; e.mf = mf; e.care_tmp = care_tmp;
    e.tmp = tmp; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // HI/LO write with no stall and no loop-back state.
  task automatic exp_wr(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    push(tag, 1'b1, 1'b0, 1'b1, hi, lo, 32'h0, 1'b1, 64'h0, 2'd0);
  endtask

  // No HI/LO write; HI/LO data is don't-care.
  task automatic exp_nowr(input string tag, input logic stall, input logic [31:0] mf);
    push(tag, 1'b0, stall, 1'b0, 32'h0, 32'h0, mf, 1'b1, 64'h0, 2'd0);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".en"},    64'(ex_en_hilo_o), 64'(e.en));
    chk({e.tag, ".stall"}, 64'(stallreq_o),   64'(e.stall));
    chk({e.tag, ".mf"},    64'(mf_data_o),    64'(e.mf));
    chk({e.tag, ".count"}, 64'(count_o),      64'(e.cnt));
    if (e.care_hl) begin
      chk({e.tag, ".hi"}, 64'(ex_hi_o), 64'(e.hi));
      chk({e.tag, ".lo"}, 64'(ex_lo_o), 64'(e.lo));
    end
    if (e.care_tmp) chk({e.tag, ".tmp"}, hilo_tmp_o, e.tmp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    check_front();
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; num1_i = a; num2_i = b;
  endtask

  // Issue a division, count the stalled cycles (issue cycle included,
  // bounded) and check the DONE cycle against the queued result.
  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] q, input logic [31:0] r);
    int n;
    set_op(op, a, b);
    exp_nowr({tag, ".issue"}, 1'b1, 32'h0);
    exp_wr({tag, ".done"}, r, q);
    sample();
    n = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      @(negedge clk);
      if (!stallreq_o) break;
      n++;
    end
    chk({tag, ".stall_cycles"}, 64'(n), 64'(exp_stall));
    check_front();
    tick();
    set_op(NOP, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0;
    set_op(NOP, 32'h0, 32'h0);
    hi_i = 32'h0; lo_i = 32'h0;
    mem_en_hilo_i = 1'b0; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
    wb_en_hilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0;
    hilo_tmp_i = 64'h0; count_i = 2'd0;
    tick(); tick();
    rst_n = 1'b1;
    push("reset", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0);
    sample(); tick();

    // Single-cycle multiplies
    set_op(MULT, 32'hFFFF_FFFE, 32'h3);
    exp_wr("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA); sample(); tick();
    set_op(MULTU, 32'hFFFF_FFFE, 32'h3);
    exp_wr("multu", 32'h0000_0002, 32'hFFFF_FFFA); sample(); tick();

    // Multiply-accumulate, two cycles each
    hi_i = 32'h0; lo_i = 32'h10;
    set_op(MADD, 32'h2, 32'h3); count_i = 2'd0; hilo_tmp_i = 64'h0;
    push("madd.c0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 64'd6, 2'd1);
    sample(); tick();
    count_i = 2'd1; hilo_tmp_i = 64'd6;
    push("madd.c1", 1'b1, 1'b0, 1'b1, 32'h0, 32'h16, 32'h0, 1'b0, 64'h0, 2'd2);
    sample(); tick();
    set_op(MSUB, 32'h2, 32'h3); count_i = 2'd0; hilo_tmp_i = 64'h0;
    push("msub.c0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 64'd6, 2'd1);
    sample(); tick();
    count_i = 2'd1; hilo_tmp_i = 64'd6;
    push("msub.c1", 1'b1, 1'b0, 1'b1, 32'h0, 32'h0A, 32'h0, 1'b0, 64'h0, 2'd2);
    sample(); tick();
    set_op(MADD, 32'hFFFF_FFFE, 32'h3); count_i = 2'd0; hilo_tmp_i = 64'h0;
    push("madd_neg.c0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFA, 2'd1);
    sample(); tick();
    count_i = 2'd1; hilo_tmp_i = 64'hFFFF_FFFF_FFFF_FFFA;
    push("madd_neg.c1", 1'b1, 1'b0, 1'b1, 32'h0, 32'h0A, 32'h0, 1'b0, 64'h0, 2'd2);
    sample(); tick();
    lo_i = 32'h0;
    set_op(MSUBU, 32'h1, 32'h1); count_i = 2'd0; hilo_tmp_i = 64'h0;
    push("msubu.c0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 64'd1, 2'd1);
    sample(); tick();
    count_i = 2'd1; hilo_tmp_i = 64'd1;
    push("msubu_wrap.c1", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0,
         64'h0, 2'd2);
    sample(); tick();
    count_i = 2'd0; hilo_tmp_i = 64'h0;

    // Divisions
    run_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    run_div("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0);
    run_div("div_by0", DIV, 32'h1234_5678, 32'h0, 2, 32'h0, 32'h0);

    // Flush at BUSY step 10, then a DIVU issued the very next cycle
    set_op(DIV, 32'd1000, 32'd3);
    exp_nowr("flush.issue", 1'b1, 32'h0); sample();
    for (int i = 0; i < 11; i++) tick();
    flush_i = 1'b1;
    exp_nowr("flush.cycle", 1'b0, 32'h0); sample(); tick();
    flush_i = 1'b0;
    run_div("divu_after_flush", DIVU, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF);

    // HI/LO forwarding priority
    hi_i = 32'h1; lo_i = 32'h11;
    wb_en_hilo_i = 1'b1; wb_hi_i = 32'h2; wb_lo_i = 32'h22;
    mem_en_hilo_i = 1'b1; mem_hi_i = 32'h3; mem_lo_i = 32'h33;
    set_op(MFHI, 32'h0, 32'h0);
    exp_nowr("mfhi_mem", 1'b0, 32'h3); sample(); tick();
    set_op(MFLO, 32'h0, 32'h0);
    exp_nowr("mflo_mem", 1'b0, 32'h33); sample(); tick();
    mem_en_hilo_i = 1'b0;
    set_op(MFHI, 32'h0, 32'h0);
    exp_nowr("mfhi_wb", 1'b0, 32'h2); sample(); tick();
    set_op(MTLO, 32'h55, 32'h0);
    exp_wr("mtlo_wb", 32'h2, 32'h55); sample(); tick();
    wb_en_hilo_i = 1'b0;
    set_op(MTHI, 32'h77, 32'h0);
    exp_wr("mthi_arch", 32'h77, 32'h11); sample(); tick();
    set_op(MFLO, 32'h0, 32'h0);
    exp_nowr("mflo_arch", 1'b0, 32'h11); sample(); tick();

    // Reset while the divider is busy
    set_op(DIV, 32'd50, 32'd5);
    exp_nowr("rst.issue", 1'b1, 32'h0); sample();
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(NOP, 32'h0, 32'h0);
    push("rst.idle", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0);
    sample(); tick();
    run_div("div_after_rst", DIV, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
